// File: rtl/rfft_loader.sv
// Input staging for the 256-point radix-2 FFT: scatters natural-order samples
// into four 64-deep banks, zero-pads short frames and hands off to the core.
module rfft_loader #(
    parameter int WIDTH  = 32,
    parameter int NPOINT = 256
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic [3:0]       wr_we,
    output logic [5:0]       wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             core_start,
    input  logic             core_done,
    output logic             busy,
    output logic             frame_err
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_PAD     = 3'd2;
    localparam logic [2:0] ST_HANDOFF = 3'd3;
    localparam logic [2:0] ST_BUSY    = 3'd4;

    localparam logic [7:0] LAST_IDX = 8'(NPOINT - 1);

    logic [2:0] state;
    logic [7:0] idx;
    logic       core_done_q;
    logic       accept;
    logic       done_rise;
    logic [3:0] bank_we;

    assign s_ready   = (state == ST_LOAD);
    assign accept    = s_valid && s_ready;
    assign done_rise = core_done && !core_done_q;

    // Bank is {n[7], n[0]}: even/odd split within each half of the frame.
    assign bank_we = 4'b0001 << {idx[7], idx[0]};

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            core_done_q <= 1'b0;
            wr_we       <= '0;
            wr_addr     <= '0;
            wr_data     <= '0;
            core_start  <= 1'b0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            wr_we       <= '0;
            core_start  <= 1'b0;
            frame_err   <= 1'b0;
            core_done_q <= core_done;

            case (state)
                ST_IDLE: begin
                    idx   <= '0;
                    state <= ST_LOAD;
                end

                ST_LOAD: begin
                    if (accept) begin
                        wr_we   <= bank_we;
                        wr_addr <= idx[6:1];
                        wr_data <= s_data;
                        idx     <= idx + 8'd1;
                        if (idx == LAST_IDX) begin
                            state <= ST_HANDOFF;
                            if (!s_last) begin
                                frame_err <= 1'b1;
                            end
                        end else if (s_last) begin
                            state     <= ST_PAD;
                            frame_err <= 1'b1;
                        end
                    end
                end

                ST_PAD: begin
                    wr_we   <= bank_we;
                    wr_addr <= idx[6:1];
                    wr_data <= '0;
                    idx     <= idx + 8'd1;
                    if (idx == LAST_IDX) begin
                        state <= ST_HANDOFF;
                    end
                end

                // One idle cycle so the final bank write lands before the core reads.
                ST_HANDOFF: begin
                    state      <= ST_BUSY;
                    core_start <= 1'b1;
                    busy       <= 1'b1;
                end

                ST_BUSY: begin
                    if (done_rise) begin
                        state <= ST_LOAD;
                        busy  <= 1'b0;
                        idx   <= '0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rfft_loader.sv
// Directed bench for rfft_loader: ramp, early/missing s_last, core_done
// handshake, mid-frame reset and a gapped frame.
module tb_rfft_loader;

    logic        Clk;
    logic        Reset_n;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic [3:0]  wr_we;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        core_start;
    logic        core_done;
    logic        busy;
    logic        frame_err;

    int assertCount = 0;
    int failCount   = 0;

    rfft_loader #(.WIDTH(32), .NPOINT(256)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .wr_we      (wr_we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .core_start (core_start),
        .core_done  (core_done),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic last);
        s_valid = valid;
        s_data  = data;
        s_last  = last;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Expected bank placement computed arithmetically from the sample index.
    task automatic checkWrite(input int n, input logic [31:0] data, input logic err);
        int bank;
        bank = ((n >= 128) ? 2 : 0) + (n % 2);
        checkOutput($sformatf("wr_we[%0d]", n), 32'(wr_we), 32'(1 << bank));
        checkOutput($sformatf("wr_addr[%0d]", n), 32'(wr_addr), 32'((n % 128) / 2));
        checkOutput($sformatf("wr_data[%0d]", n), wr_data, data);
        checkOutput($sformatf("frame_err[%0d]", n), 32'(frame_err), 32'(err));
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_s_ready"}, 32'(s_ready), 0);
        checkOutput({tag, "_wr_we"}, 32'(wr_we), 0);
        checkOutput({tag, "_wr_addr"}, 32'(wr_addr), 0);
        checkOutput({tag, "_wr_data"}, wr_data, 0);
        checkOutput({tag, "_core_start"}, 32'(core_start), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_frame_err"}, 32'(frame_err), 0);
    endtask

    initial begin
        int prevN;
        int nextN;
        int obsWrites;
        bit prevValid;
        bit v;
        bit seenReady;

        Reset_n   = 1'b0;
        core_done = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0);
        repeat (3) tick();
        checkIdleOutputs("reset");

        Reset_n = 1'b1;
        seenReady = 1'b0;
        for (int i = 0; i < 10 && !seenReady; i++) begin
            tick();
            seenReady = s_ready;
        end
        checkOutput("ready_after_reset", 32'(s_ready), 1);

        $display("[TB] full ramp frame");
        for (int n = 0; n < 256; n++) begin
            applyStimulus(1'b1, 32'(n), n == 255);
            tick();
            checkWrite(n, 32'(n), 1'b0);
        end
        checkOutput("ramp_handoff_ready", 32'(s_ready), 0);
        checkOutput("ramp_handoff_start", 32'(core_start), 0);
        tick();
        checkOutput("ramp_core_start", 32'(core_start), 1);
        checkOutput("ramp_busy", 32'(busy), 1);
        checkOutput("ramp_start_no_we", 32'(wr_we), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_ready", 32'(s_ready), 0);
            checkOutput("bp_we", 32'(wr_we), 0);
            checkOutput("bp_busy", 32'(busy), 1);
            checkOutput("bp_start_once", 32'(core_start), 0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0);
        core_done = 1'b1;
        tick();
        checkOutput("done_rise_busy", 32'(busy), 0);
        checkOutput("done_rise_ready", 32'(s_ready), 1);

        $display("[TB] early s_last at 99");
        for (int n = 0; n < 100; n++) begin
            applyStimulus(1'b1, 32'(n + 1000), n == 99);
            tick();
            checkWrite(n, 32'(n + 1000), n == 99);
        end
        applyStimulus(1'b0, 32'h0, 1'b0);
        for (int k = 100; k < 256; k++) begin
            tick();
            checkWrite(k, 32'h0, 1'b0);
            checkOutput("pad_ready", 32'(s_ready), 0);
        end
        checkOutput("pad_handoff_start", 32'(core_start), 0);
        tick();
        checkOutput("pad_core_start", 32'(core_start), 1);
        checkOutput("pad_busy", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("done_high_no_exit", 32'(busy), 1);
            checkOutput("done_high_ready", 32'(s_ready), 0);
        end
        core_done = 1'b0;
        tick();
        checkOutput("done_low_busy", 32'(busy), 1);
        core_done = 1'b1;
        tick();
        checkOutput("done_rise2_busy", 32'(busy), 0);
        checkOutput("done_rise2_ready", 32'(s_ready), 1);

        $display("[TB] missing s_last");
        for (int n = 0; n < 256; n++) begin
            applyStimulus(1'b1, 32'(n) ^ 32'hA5A5_0000, 1'b0);
            tick();
            checkWrite(n, 32'(n) ^ 32'hA5A5_0000, n == 255);
        end
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("miss_handoff_start", 32'(core_start), 0);
        tick();
        checkOutput("miss_core_start", 32'(core_start), 1);
        checkOutput("miss_err_once", 32'(frame_err), 0);
        core_done = 1'b0;
        tick();
        core_done = 1'b1;
        tick();
        checkOutput("miss_exit_ready", 32'(s_ready), 1);

        $display("[TB] reset mid-frame");
        for (int n = 0; n < 40; n++) begin
            applyStimulus(1'b1, 32'(n), 1'b0);
            tick();
            checkWrite(n, 32'(n), 1'b0);
        end
        applyStimulus(1'b1, 32'd40, 1'b0);
        Reset_n = 1'b0;
        tick();
        checkIdleOutputs("midreset");
        Reset_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("postreset_ready", 32'(s_ready), 1);
        checkOutput("postreset_no_start", 32'(core_start), 0);

        $display("[TB] gapped frame");
        prevValid = 1'b0;
        prevN     = 0;
        nextN     = 0;
        obsWrites = 0;
        for (int cyc = 0; cyc < 3000 && obsWrites < 256; cyc++) begin
            if (cyc > 0) begin
                tick();
                if (wr_we != 4'b0) obsWrites++;
                if (prevValid) checkWrite(prevN, 32'(prevN) + 32'h0001_0000, 1'b0);
                else checkOutput("gap_no_write", 32'(wr_we), 0);
                checkOutput("gap_no_start", 32'(core_start), 0);
            end
            if (nextN < 256) begin
                v = (cyc == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                if (v) begin
                    applyStimulus(1'b1, 32'(nextN) + 32'h0001_0000, nextN == 255);
                    prevN = nextN;
                    nextN++;
                end else begin
                    applyStimulus(1'b0, 32'h0, 1'b0);
                end
                prevValid = v;
            end else begin
                applyStimulus(1'b0, 32'h0, 1'b0);
                prevValid = 1'b0;
            end
        end
        checkOutput("gap_total_writes", 32'(obsWrites), 256);
        checkOutput("gap_handoff_start", 32'(core_start), 0);
        tick();
        checkOutput("gap_core_start", 32'(core_start), 1);
        checkOutput("gap_busy", 32'(busy), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
